// File: rtl/bus_interface_unit_pkg.sv
// bus_interface_pkg: shared types and constants for the bus interface unit.
//   biu_state_t : access sequencer states
//   ERR_RDATA   : read data returned on a timed-out read (all ones), sliced
//                 to DATA_WIDTH by the user (DATA_WIDTH up to 64)
package bus_interface_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE,
    ERROR
  } biu_state_t;

  localparam int          ERR_RDATA_MAX_W = 64;
  localparam logic [63:0] ERR_RDATA       = '1;

endpackage

// File: rtl/bus_interface_unit_if.sv
// bus_interface_unit_if: CPU-side request/acknowledge signals and the
// external memory pins of the bus interface unit, bundled together.
//   slave  : view of the bus interface unit itself
//   master : view of the environment (CPU core + memory) driving it
interface bus_interface_unit_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  // CPU side
  logic                     cpu_req;
  logic                     cpu_write;
  logic [ADDR_WIDTH-1:0]    cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic                     cpu_ack;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_error;
  logic                     busy;
  logic [ERR_CNT_WIDTH-1:0] error_count;
  // Memory side
  logic                     mem_strobe;
  logic                     READ_write;
  logic [ADDR_WIDTH-1:0]    address_out;
  logic [DATA_WIDTH-1:0]    data_out;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     mem_ready;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, data_in, mem_ready,
    output cpu_ack, cpu_rdata, cpu_error, busy, error_count,
           mem_strobe, READ_write, address_out, data_out
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, data_in, mem_ready,
    input  cpu_ack, cpu_rdata, cpu_error, busy, error_count,
           mem_strobe, READ_write, address_out, data_out
  );
endinterface

// File: rtl/bus_interface_unit_wait_state_counter.sv
// wait_state_counter: up counter with synchronous clear and count enable,
// plus a compare against a terminal value.
//   clk_in, reset : clock, asynchronous active-high reset
//   clear         : load zero (has priority over enable)
//   enable        : increment by one
//   terminal      : value compared against the current count
//   at_terminal   : current count equals terminal
module wait_state_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign at_terminal = (count_reg == terminal);

endmodule

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: request/acknowledge bridge between the CPU core and
// external memory. One access in flight; optional setup wait states,
// mem_ready stretching, timeout with error pulse, saturating error counter.
//   clk_in : system clock, rising edge
//   reset  : asynchronous active-high reset (drops any access, no ack)
//   bus    : CPU request/ack/data and memory strobe/address/data/ready
module bus_interface_unit
  import bus_interface_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int FIXED_WAIT    = 0,
  parameter int TIMEOUT       = 15,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  bus_interface_unit_if.slave  bus
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counters compare against "last cycle" so the FSM leaves on that cycle.
  localparam logic [3:0]        SETUP_LAST = (FIXED_WAIT > 0) ? 4'(FIXED_WAIT - 1) : 4'd0;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
  localparam logic [DATA_WIDTH-1:0] RDATA_ON_ERR = ERR_RDATA[DATA_WIDTH-1:0];

  biu_state_t state_reg, state_next;

  logic                     write_reg;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic [DATA_WIDTH-1:0]    rdata_reg;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg;

  logic setup_done;
  logic wait_expired;

  // Counters sit at zero whenever their state is not active, so they are
  // always clear on entry to SETUP/ACCESS.
  wait_state_counter #(.WIDTH(4)) u_setup_cnt (
    .clk_in      (clk_in),
    .reset       (reset),
    .clear       (state_reg != SETUP),
    .enable      (state_reg == SETUP),
    .terminal    (SETUP_LAST),
    .at_terminal (setup_done)
  );

  wait_state_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk_in      (clk_in),
    .reset       (reset),
    .clear       (state_reg != ACCESS),
    .enable      ((state_reg == ACCESS) && !bus.mem_ready),
    .terminal    (WAIT_LAST),
    .at_terminal (wait_expired)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cpu_req) begin
          state_next = (FIXED_WAIT > 0) ? SETUP : ACCESS;
        end
      end
      SETUP: begin
        if (setup_done) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // A ready on the last allowed cycle still completes normally.
        if (bus.mem_ready) begin
          state_next = DONE;
        end else if ((TIMEOUT != 0) && wait_expired) begin
          state_next = ERROR;
        end
      end
      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      err_cnt_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && bus.cpu_req) begin
        write_reg <= bus.cpu_write;
        addr_reg  <= bus.cpu_addr;
        wdata_reg <= bus.cpu_wdata;
      end
      // Read data and error count are updated on entry to DONE/ERROR so they
      // are already valid while cpu_ack is high.
      if ((state_reg == ACCESS) && (state_next == DONE) && !write_reg) begin
        rdata_reg <= bus.data_in;
      end
      if ((state_reg == ACCESS) && (state_next == ERROR)) begin
        if (!write_reg) begin
          rdata_reg <= RDATA_ON_ERR;
        end
        if (err_cnt_reg != '1) begin
          err_cnt_reg <= err_cnt_reg + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.mem_strobe  = (state_reg == SETUP) || (state_reg == ACCESS);
  assign bus.READ_write  = bus.mem_strobe && write_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.cpu_ack     = (state_reg == DONE) || (state_reg == ERROR);
  assign bus.cpu_error   = (state_reg == ERROR);
  assign bus.address_out = addr_reg;
  assign bus.data_out    = wdata_reg;
  assign bus.cpu_rdata   = rdata_reg;
  assign bus.error_count = err_cnt_reg;

endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: randomized scoreboard bench for bus_interface_unit.
// The stimulus process issues accesses, plays the memory (ready after a
// chosen number of not-ready ACCESS cycles) and pushes the expected outcome;
// a negedge monitor checks per-cycle bus behaviour and pops on each cpu_ack.
module tb_bus_interface_unit;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int EW = 8;
  localparam int FW = 2;
  localparam int TO = 15;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic [EW-1:0] ecnt;
    int            c0;
    int            ack;
  } exp_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  bus_interface_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) bif ();

  bus_interface_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_WAIT(FW), .TIMEOUT(TO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bif)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   txn_no = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  logic [DW-1:0] rdata_model = '0;
  logic [EW-1:0] err_model   = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},        32'(bif.busy),        0);
    chk({tag, "_strobe"},      32'(bif.mem_strobe),  0);
    chk({tag, "_read_write"},  32'(bif.READ_write),  0);
    chk({tag, "_ack"},         32'(bif.cpu_ack),     0);
    chk({tag, "_error"},       32'(bif.cpu_error),   0);
    chk({tag, "_address_out"}, 32'(bif.address_out), 0);
    chk({tag, "_data_out"},    32'(bif.data_out),    0);
    chk({tag, "_rdata"},       32'(bif.cpu_rdata),   0);
    chk({tag, "_error_count"}, 32'(bif.error_count), 0);
  endtask

  // Monitor: per-cycle shape of busy/strobe/READ_write against the oldest
  // outstanding access, and a full result check on every DUT acknowledge.
  exp_t mon_e;
  bit   exp_busy, exp_strobe;
  always @(negedge clk_in) begin
    if (mon_en) begin
      exp_busy   = 1'b0;
      exp_strobe = 1'b0;
      if (sb_q.size() > 0) begin
        mon_e      = sb_q[0];
        exp_busy   = (cyc > mon_e.c0) && (cyc <= mon_e.ack);
        exp_strobe = (cyc > mon_e.c0) && (cyc < mon_e.ack);
        if (cyc > mon_e.c0) begin
          chk("address_out", 32'(bif.address_out), 32'(mon_e.addr));
          chk("data_out",    32'(bif.data_out),    32'(mon_e.wdata));
        end
        chk("read_write", 32'(bif.READ_write), 32'(exp_strobe && mon_e.wr));
      end else begin
        chk("read_write", 32'(bif.READ_write), 0);
      end
      chk("busy",       32'(bif.busy),       32'(exp_busy));
      chk("mem_strobe", 32'(bif.mem_strobe), 32'(exp_strobe));
      if (!bif.cpu_ack) begin
        chk("error_without_ack", 32'(bif.cpu_error), 0);
      end else if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'(bif.cpu_ack), 0);
      end else begin
        mon_e = sb_q.pop_front();
        txn_no++;
        chk("ack_cycle",   32'(cyc),             32'(mon_e.ack));
        chk("cpu_error",   32'(bif.cpu_error),   32'(mon_e.err));
        chk("cpu_rdata",   32'(bif.cpu_rdata),   32'(mon_e.rdata));
        chk("error_count", 32'(bif.error_count), 32'(mon_e.ecnt));
        $display("txn %0d: %s addr=0x%04h ack_cycle=%0d err=%0d rdata=0x%02h ecnt=%0d",
                 txn_no, mon_e.wr ? "WR" : "RD", mon_e.addr, cyc,
                 bif.cpu_error, bif.cpu_rdata, bif.error_count);
      end
    end
  end

  // Issue one access at the current negedge (BIU idle) and act as memory:
  // d not-ready ACCESS cycles, then ready with data rd. Returns at the first
  // negedge where the BIU is idle again.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int d);
    exp_t e;
    int   ready_k;
    int   k;
    bit   timed_out;
    timed_out = (TO != 0) && (d >= TO);
    ready_k   = FW + 1 + d;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    e.err   = timed_out;
    e.c0    = cyc;
    e.ack   = cyc + (timed_out ? (FW + 1 + TO) : (FW + 2 + d));
    if (timed_out) begin
      if (!wr) rdata_model = '1;
      if (err_model != '1) err_model = err_model + 1'b1;
    end else if (!wr) begin
      rdata_model = rd;
    end
    e.rdata = rdata_model;
    e.ecnt  = err_model;
    sb_q.push_back(e);

    bif.cpu_req   = 1'b1;
    bif.cpu_write = wr;
    bif.cpu_addr  = a;
    bif.cpu_wdata = wd;
    bif.mem_ready = 1'($urandom);
    bif.data_in   = DW'($urandom);
    for (k = 1; k <= FW + TO + 20; k++) begin
      @(negedge clk_in);
      if (!bif.busy) break;
      // CPU side may change freely while busy; the BIU must ignore it.
      bif.cpu_req   = 1'($urandom);
      bif.cpu_write = 1'($urandom);
      bif.cpu_addr  = AW'($urandom);
      bif.cpu_wdata = DW'($urandom);
      if (k == ready_k) begin
        bif.mem_ready = 1'b1;
        bif.data_in   = rd;
      end else if ((k <= FW) || (k > ready_k)) begin
        bif.mem_ready = 1'($urandom);
        bif.data_in   = DW'($urandom);
      end else begin
        bif.mem_ready = 1'b0;
        bif.data_in   = DW'($urandom);
      end
    end
    chk("accept_period", 32'(k), 32'(e.ack - e.c0 + 1));
  endtask

  task automatic idle_gap(input int n);
    bif.cpu_req   = 1'b0;
    bif.cpu_addr  = AW'($urandom);
    bif.cpu_wdata = DW'($urandom);
    bif.mem_ready = 1'($urandom);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin : stim
    int acks_seen;
    bif.cpu_req   = 1'b0;
    bif.cpu_write = 1'b0;
    bif.cpu_addr  = '0;
    bif.cpu_wdata = '0;
    bif.data_in   = '0;
    bif.mem_ready = 1'b0;

    // Reset state.
    #2 reset = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check_all_zero("post_reset");

    // Reset in the middle of an ACCESS of a read: no ack may ever follow.
    bif.cpu_req   = 1'b1;
    bif.cpu_write = 1'b0;
    bif.cpu_addr  = 16'h1234;
    bif.cpu_wdata = 8'h00;
    repeat (FW + 1) @(negedge clk_in);
    bif.cpu_req = 1'b0;
    chk("pre_reset_busy",    32'(bif.busy),        1);
    chk("pre_reset_address", 32'(bif.address_out), 32'h1234);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_access_reset");
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    bif.mem_ready = 1'b1;
    bif.data_in   = 8'hEE;
    acks_seen = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (bif.cpu_ack) acks_seen++;
    end
    chk("no_ack_after_reset", 32'(acks_seen), 0);
    check_all_zero("after_reset_release");

    mon_en = 1'b1;

    // Directed cases.
    run_txn(1'b0, 16'h1234, 8'h00, 8'hA5, 0);        // read, ready at once
    run_txn(1'b1, 16'h0200, 8'h3C, 8'h00, 0);        // write, ready at once
    run_txn(1'b0, 16'h4321, 8'h11, 8'h5A, TO - 1);   // ready on last allowed cycle
    run_txn(1'b0, 16'h0BAD, 8'h00, 8'h77, TO);       // read timeout
    run_txn(1'b1, 16'h0BEE, 8'h99, 8'h00, TO + 3);   // write timeout, rdata kept
    idle_gap(3);

    // Random mix with back-to-back requests and occasional idle gaps.
    repeat (150) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(0, TO + 2));
      if ($urandom_range(0, 7) == 0) idle_gap($urandom_range(1, 3));
    end

    // Timeout storm: the error counter must saturate.
    repeat (300) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), TO + $urandom_range(0, 3));
    end

    repeat (50) begin
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(0, TO + 2));
    end

    idle_gap(4);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
